// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard scan-code decoder.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT_PREFIX   = 8'hE0;
  localparam logic [7:0] PS2_BREAK_PREFIX = 8'hF0;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } key_event_t;

  typedef enum logic [1:0] {
    StIdle,
    StExt,
    StBrk,
    StExtBrk
  } dec_state_t;

endpackage

// File: rtl/ps2_event_fifo.sv
// First-word-fall-through event FIFO with a sticky overflow flag.
module ps2_event_fifo
  import ps2_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter type         T     = key_event_t
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  T     push_data,
  input  logic pop,
  input  logic clr_ovf,
  output logic valid,
  output T     head,
  output logic overflow
);

  localparam int unsigned AW = $clog2(DEPTH);

  T               mem_q [DEPTH];
  logic [AW-1:0]  wr_q, rd_q;
  logic [AW:0]    cnt_q;
  logic           ovf_q;
  logic           empty, full, do_pop, do_push, drop;

  always_comb begin
    empty   = (cnt_q == '0);
    full    = (cnt_q == (AW + 1)'(DEPTH));
    do_pop  = pop && !empty;
    // A push into a full FIFO still lands when the head leaves on the same cycle.
    do_push = push && (!full || do_pop);
    drop    = push && full && !do_pop;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
      if (drop)         ovf_q <= 1'b1;
      else if (clr_ovf) ovf_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= push_data;
  end

  // Head is forced to zero while empty so reset leaves clean outputs.
  assign valid    = !empty;
  assign head     = empty ? T'('0) : mem_q[rd_q];
  assign overflow = ovf_q;

endmodule

// File: rtl/ps2_keyboard_ctrl.sv
// PS/2 set-2 scan-code decoder: folds E0/F0 prefixes into key events and queues them.
module ps2_keyboard_ctrl
  import ps2_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned PREFIX_TIMEOUT = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       rx_err,
  input  logic       rd_en,
  input  logic       clr_ovf,
  output logic       key_valid,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_break,
  output logic       overflow,
  output logic [7:0] err_count
);

  localparam int unsigned TW = $clog2(PREFIX_TIMEOUT + 1);

  dec_state_t  state_q, state_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [7:0]  err_q;
  logic        push;
  key_event_t  push_ev, head;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      tmo_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      if (rx_valid && rx_err && err_q != 8'hFF) err_q <= err_q + 8'd1;
    end
  end

  always_comb begin
    state_d      = state_q;
    tmo_d        = tmo_q;
    push         = 1'b0;
    push_ev.ext  = (state_q == StExt) || (state_q == StExtBrk);
    push_ev.brk  = (state_q == StBrk) || (state_q == StExtBrk);
    push_ev.code = rx_data;
    if (rx_valid) begin
      tmo_d = '0;
      if (rx_err) begin
        state_d = StIdle;
      end else begin
        case (state_q)
          StIdle: begin
            if (rx_data == PS2_EXT_PREFIX)        state_d = StExt;
            else if (rx_data == PS2_BREAK_PREFIX) state_d = StBrk;
            else                                  push    = 1'b1;
          end
          StExt: begin
            if (rx_data == PS2_BREAK_PREFIX)    state_d = StExtBrk;
            else if (rx_data == PS2_EXT_PREFIX) state_d = StExt;
            else begin
              push    = 1'b1;
              state_d = StIdle;
            end
          end
          default: begin
            // A prefix after F0 is malformed: drop the whole sequence.
            if (rx_data != PS2_EXT_PREFIX && rx_data != PS2_BREAK_PREFIX) push = 1'b1;
            state_d = StIdle;
          end
        endcase
      end
    end else if (state_q != StIdle) begin
      if (tmo_q == TW'(PREFIX_TIMEOUT - 1)) begin
        state_d = StIdle;
        tmo_d   = '0;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
  end

  ps2_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (key_event_t)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_ev),
    .pop       (rd_en),
    .clr_ovf   (clr_ovf),
    .valid     (key_valid),
    .head      (head),
    .overflow  (overflow)
  );

  assign key_code  = head.code;
  assign key_ext   = head.ext;
  assign key_break = head.brk;
  assign err_count = err_q;

endmodule

// File: tb/tb_ps2_keyboard_ctrl.sv
// Bench for ps2_keyboard_ctrl: directed table, corner sequences and random traffic vs a model.
module tb_ps2_keyboard_ctrl;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned PT    = 20;

  logic       clk = 1'b0;
  logic       rst, rx_valid, rx_err, rd_en, clr_ovf;
  logic [7:0] rx_data;
  logic       key_valid, key_ext, key_break, overflow;
  logic [7:0] key_code, err_count;

  ps2_keyboard_ctrl #(
    .FIFO_DEPTH     (DEPTH),
    .PREFIX_TIMEOUT (PT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_err    (rx_err),
    .rd_en     (rd_en),
    .clr_ovf   (clr_ovf),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_ext   (key_ext),
    .key_break (key_break),
    .overflow  (overflow),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: pending-prefix flags, an event queue, and counters.
  logic [9:0] mq[$];
  bit         m_ext, m_brk, m_ovf;
  int         m_idle, m_err;

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       e;
    logic       rd;
    logic       ev_valid;
    logic [9:0] ev;
    logic [7:0] errc;
  } vec_t;

  vec_t tbl[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit v, input bit e, input logic [7:0] d,
                            input bit rd, input bit clr);
    bit         push, full, popd, drop;
    logic [9:0] ev;
    if (r) begin
      mq.delete();
      m_ext = 0; m_brk = 0; m_idle = 0; m_err = 0; m_ovf = 0;
      return;
    end
    push = 0;
    ev   = '0;
    if (v) begin
      m_idle = 0;
      if (e) begin
        m_ext = 0; m_brk = 0;
        if (m_err < 255) m_err++;
      end else if (d == 8'hE0 || d == 8'hF0) begin
        if (m_brk) begin
          m_ext = 0; m_brk = 0;
        end else if (d == 8'hE0) m_ext = 1;
        else m_brk = 1;
      end else begin
        push = 1;
        ev   = {m_ext, m_brk, d};
        m_ext = 0; m_brk = 0;
      end
    end else if (m_ext || m_brk) begin
      m_idle++;
      if (m_idle == PT) begin
        m_ext = 0; m_brk = 0; m_idle = 0;
      end
    end
    full = (mq.size() == DEPTH);
    popd = rd && (mq.size() > 0);
    drop = push && full && !popd;
    if (popd) void'(mq.pop_front());
    if (push && !drop) mq.push_back(ev);
    if (drop) m_ovf = 1;
    else if (clr) m_ovf = 0;
  endtask

  task automatic compare_model();
    check("key_valid", 32'(key_valid), 32'(mq.size() > 0));
    if (mq.size() > 0) check("head_event", {22'd0, key_ext, key_break, key_code}, 32'(mq[0]));
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("err_count", 32'(err_count), 32'(m_err));
  endtask

  task automatic cyc(input bit r, input bit v, input bit e, input logic [7:0] d,
                     input bit rd, input bit clr);
    rst = r; rx_valid = v; rx_err = e; rx_data = d; rd_en = rd; clr_ovf = clr;
    @(posedge clk);
    model_step(r, v, e, d, rd, clr);
    #1;
    compare_model();
  endtask

  task automatic send(input logic [7:0] d);
    cyc(0, 1, 0, d, 0, 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 8'h00, 0, 0);
  endtask

  task automatic pop1();
    cyc(0, 0, 0, 8'h00, 1, 0);
  endtask

  task automatic check_head(input string name, input logic [9:0] exp);
    check({name, "_valid"}, 32'(key_valid), 32'd1);
    check(name, {22'd0, key_ext, key_break, key_code}, 32'(exp));
  endtask

  initial begin
    rst = 1; rx_valid = 0; rx_err = 0; rx_data = '0; rd_en = 0; clr_ovf = 0;

    // Reset state
    cyc(1, 0, 0, 8'h00, 0, 0);
    cyc(1, 0, 0, 8'h00, 0, 0);
    check("rst_valid", 32'(key_valid), 32'd0);
    check("rst_code", 32'(key_code), 32'd0);
    check("rst_ext_brk", 32'({key_ext, key_break}), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_err", 32'(err_count), 32'd0);

    // Directed table: single make, break/ext sequences, error strobe
    tbl[0]  = '{1'b1, 8'h1C, 1'b0, 1'b0, 1'b1, 10'h01C, 8'd0};
    tbl[1]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 10'h000, 8'd0};
    tbl[2]  = '{1'b1, 8'hF0, 1'b0, 1'b0, 1'b0, 10'h000, 8'd0};
    tbl[3]  = '{1'b1, 8'h1C, 1'b0, 1'b0, 1'b1, 10'h11C, 8'd0};
    tbl[4]  = '{1'b1, 8'hE0, 1'b0, 1'b0, 1'b1, 10'h11C, 8'd0};
    tbl[5]  = '{1'b1, 8'h75, 1'b0, 1'b0, 1'b1, 10'h11C, 8'd0};
    tbl[6]  = '{1'b1, 8'hE0, 1'b0, 1'b0, 1'b1, 10'h11C, 8'd0};
    tbl[7]  = '{1'b1, 8'hF0, 1'b0, 1'b0, 1'b1, 10'h11C, 8'd0};
    tbl[8]  = '{1'b1, 8'h75, 1'b0, 1'b0, 1'b1, 10'h11C, 8'd0};
    tbl[9]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 10'h275, 8'd0};
    tbl[10] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 10'h375, 8'd0};
    tbl[11] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 10'h000, 8'd0};
    tbl[12] = '{1'b1, 8'h1C, 1'b1, 1'b0, 1'b0, 10'h000, 8'd1};
    for (int i = 0; i < 13; i++) begin
      cyc(0, tbl[i].v, tbl[i].e, tbl[i].d, tbl[i].rd, 0);
      check($sformatf("tbl%0d_valid", i), 32'(key_valid), 32'(tbl[i].ev_valid));
      if (tbl[i].ev_valid)
        check($sformatf("tbl%0d_event", i), {22'd0, key_ext, key_break, key_code}, 32'(tbl[i].ev));
      check($sformatf("tbl%0d_err", i), 32'(err_count), 32'(tbl[i].errc));
    end

    // Error counter saturation
    for (int i = 0; i < 299; i++) cyc(0, 1, 1, 8'(i), 0, 0);
    check("err_sat", 32'(err_count), 32'd255);
    check("err_no_event", 32'(key_valid), 32'd0);

    // Prefix timeout, and one cycle short of it
    cyc(1, 0, 0, 8'h00, 0, 0);
    send(8'hE0);
    idle(PT + 1);
    send(8'h1C);
    check_head("timeout_event", 10'h01C);
    pop1();
    send(8'hE0);
    idle(PT - 1);
    send(8'h1C);
    check_head("no_timeout_event", 10'h21C);
    pop1();
    check("timeout_empty", 32'(key_valid), 32'd0);

    // Overflow: DEPTH+1 pushes, first DEPTH retained in order
    for (int i = 0; i < DEPTH + 1; i++) send(8'h10 + 8'(i));
    check("ovf_set", 32'(overflow), 32'd1);
    for (int i = 0; i < DEPTH; i++) begin
      check_head($sformatf("ovf_pop%0d", i), 10'h010 + 10'(i));
      pop1();
    end
    check("ovf_drained", 32'(key_valid), 32'd0);
    cyc(0, 0, 0, 8'h00, 0, 1);
    check("ovf_clr", 32'(overflow), 32'd0);

    // Push and pop together while full
    for (int i = 0; i < DEPTH; i++) send(8'h20 + 8'(i));
    cyc(0, 1, 0, 8'h28, 1, 0);
    check("full_pp_ovf", 32'(overflow), 32'd0);
    for (int i = 0; i < DEPTH; i++) begin
      check_head($sformatf("full_pp_pop%0d", i), 10'h021 + 10'(i));
      pop1();
    end
    check("full_pp_empty", 32'(key_valid), 32'd0);

    // Push and pop together with one entry
    send(8'h30);
    cyc(0, 1, 0, 8'h31, 1, 0);
    check_head("one_pp", 10'h031);
    pop1();

    // Dropping push coinciding with clr_ovf keeps overflow set
    for (int i = 0; i < DEPTH; i++) send(8'h40 + 8'(i));
    cyc(0, 1, 0, 8'h50, 0, 1);
    check("clr_vs_drop", 32'(overflow), 32'd1);

    // Reset mid-sequence, rx_valid during reset ignored
    cyc(1, 0, 0, 8'h00, 0, 0);
    send(8'hE0);
    cyc(1, 1, 0, 8'h1C, 0, 0);
    check("rst_ignore_valid", 32'(key_valid), 32'd0);
    send(8'hF0);
    send(8'h1C);
    check_head("rst_mid_seq", 10'h11C);
    pop1();

    // Random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      bit         v, e, rd, clr, r;
      logic [7:0] d;
      int         sel;
      sel = int'($urandom_range(0, 7));
      d   = (sel == 0) ? 8'hE0 : (sel == 1) ? 8'hF0 : 8'($urandom);
      v   = ($urandom_range(0, 2) == 0);
      e   = ($urandom_range(0, 19) == 0);
      rd  = ((i / 500) % 2 == 1) ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 7) == 0);
      clr = ($urandom_range(0, 29) == 0);
      r   = ($urandom_range(0, 499) == 0);
      cyc(r, v, e, d, rd, clr);
      if ($urandom_range(0, 99) == 0) idle(PT - 1 + int'($urandom_range(0, 2)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
